mem_completion_tracker: RTL
===========================

Name: mem_completion_tracker

Overview:
- Parametrised successor to the memory controller's single-shot completion logic.
- Records every issued memory request (read or write) in an in-order tracking queue of depth DEPTH.
- On each completion strobe from the memory side, retires the oldest request and produces a registered one-cycle acknowledge. For reads, it also latches the returned data.
- Sits between the memory controller request path and the CPU-side response path. It detects stray completions and, optionally, stalled requests.

Parameters:
- DATA_W, 16, width of read data path.
- DEPTH, 4, maximum outstanding requests; power of two, >= 2.
- TIMEOUT_CYC, 255, cycles the oldest request may wait before timeout (used only with MCT_TIMEOUT_EN); must be < 2**16.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request issued this cycle.
- req_we  input  1  request type qualifier: 1 = write, 0 = read.
- req_ready  output  1  tracker can accept a request.
- cmp_i  input  1  memory completion strobe (oldest request done).
- cmp_data  input  DATA_W  read data, valid with cmp_i.
- ack  output  1  one-cycle completion acknowledge.
- ack_we  output  1  type of the acknowledged request, valid with ack.
- data_out  output  DATA_W  last completed read data.
- outstanding  output  $clog2(DEPTH)+1  number of tracked requests.
- busy  output  1  outstanding != 0.
- err_unexpected  output  1  one-cycle pulse on a completion with empty queue.
- timeout_o  output  1  sticky timeout flag.

Behaviour:
- Reset is asynchronous and active-high. While rst=1, all of the following are 0: queue pointers, outstanding, ack, ack_we, data_out, err_unexpected, timeout_o, and the age counter. req_ready=1 after reset. Any in-flight requests are discarded; a completion arriving after reset is therefore flagged as unexpected.
- Queue:
  - DEPTH entries of 1 bit each (the req_we value), with write and read pointers of $clog2(DEPTH) bits.
  - Pointers wrap modulo DEPTH.
  - outstanding is a registered count.
- req_ready = (outstanding != DEPTH). It is derived from registered state only, with no combinational path from cmp_i.
- Push: req_valid & req_ready stores req_we at the write pointer, then advances it.
- Push when full: req_valid & ~req_ready is dropped; queue state is unchanged.
- Pop: cmp_i & busy. On the next clock edge:
  - ack=1.
  - ack_we = the head entry.
  - If the head entry is a read, data_out <= cmp_data.
  - The read pointer advances.
- Latency: ack is asserted exactly 1 cycle after the cmp_i cycle. ack is 0 in every other cycle.
- data_out holds its value until the next read completion. Write completions do not change it.
- Simultaneous push and pop in one cycle: both take effect and outstanding is unchanged. When the queue is full, req_ready=0, so a same-cycle push is still dropped.
- Completion with empty queue (cmp_i & ~busy): no pop and ack stays 0. err_unexpected=1 for exactly one cycle, in the following cycle.
- outstanding never exceeds DEPTH and never underflows.
- State summary: EMPTY (outstanding=0), PARTIAL, FULL (outstanding=DEPTH). Transitions are driven purely by the push/pop rules above.

Optional Feature:
- Macro: MCT_TIMEOUT_EN.
- Defined:
  - A 16-bit age counter clears on any pop and whenever busy=0. It increments each cycle while busy=1 and no pop occurs.
  - When age reaches TIMEOUT_CYC, timeout_o is set. It stays set until rst.
  - The counter saturates at TIMEOUT_CYC.
- Not defined: no counter is synthesised and timeout_o is tied to 0.

Test Plan:
- Reset release then single read: req_valid=1, req_we=0 at cycle 0; cmp_i=1, cmp_data=16'hBEEF at cycle 3. Required: ack=1, ack_we=0, data_out=16'hBEEF at cycle 4; outstanding returns 0.
- Mixed order: issue W, R, W; complete with data 16'h0001, 16'h1234, 16'h0002. Required:
  - ack_we sequence is 1, 0, 1.
  - data_out=16'h1234 after the second ack and stays 16'h1234 after the third.
- Full queue (DEPTH=4): issue 5 back-to-back reads. Required: req_ready=0 after the 4th; the 5th is dropped; outstanding=4; exactly 4 acks after 4 completions.
- Simultaneous push/pop at outstanding=2: req_valid=1 and cmp_i=1 in the same cycle. Required: outstanding stays 2 and ack pulses once.
- Stray completion: cmp_i=1 with empty queue. Required: err_unexpected=1 for one cycle, ack=0, data_out unchanged. Assert rst with 3 outstanding, then cmp_i. Required: err_unexpected pulse and outstanding=0.
- With MCT_TIMEOUT_EN and TIMEOUT_CYC=8: issue one read and never complete it. Required: timeout_o=1 after 8 cycles and it remains 1 after a later completion. Without the macro, timeout_o=0 throughout.

Source files
------------

// File: rtl/mem_completion_tracker.sv
// In-order tracker for outstanding memory requests: retires the oldest entry on each
// completion strobe, flags stray completions and, with MCT_TIMEOUT_EN, stalled heads.
module mem_completion_tracker #(
  parameter int DATA_W      = 16,
  parameter int DEPTH       = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  input  logic                       req_we,
  output logic                       req_ready,
  input  logic                       cmp_i,
  input  logic [DATA_W-1:0]          cmp_data,
  output logic                       ack,
  output logic                       ack_we,
  output logic [DATA_W-1:0]          data_out,
  output logic [$clog2(DEPTH):0]     outstanding,
  output logic                       busy,
  output logic                       err_unexpected,
  output logic                       timeout_o
);
  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("DEPTH must be a power of two >= 2");
  end
  if ((TIMEOUT_CYC < 1) || (TIMEOUT_CYC >= 65536)) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be in 1..65535");
  end

  logic [DEPTH-1:0]  queue_q, queue_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ack_q, ack_d;
  logic              ack_we_q, ack_we_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              err_q, err_d;
  logic              timeout_q, timeout_d;
  logic              push, pop, head_we;

`ifdef MCT_TIMEOUT_EN
  localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYC);
  logic [15:0] age_q, age_d;
`endif

  // Readiness and busy come only from registered count, never from cmp_i.
  assign req_ready = (cnt_q != FULL_CNT);
  assign busy      = (cnt_q != '0);

  always_comb begin
    push     = req_valid & req_ready;
    pop      = cmp_i & busy;
    head_we  = queue_q[rd_ptr_q];
    queue_d  = queue_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      queue_d[wr_ptr_q] = req_we;
      wr_ptr_d          = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    ack_d    = pop;
    ack_we_d = pop & head_we;
    data_d   = (pop & ~head_we) ? cmp_data : data_q;
    err_d    = cmp_i & ~busy;
`ifdef MCT_TIMEOUT_EN
    if (pop || !busy)       age_d = '0;
    else if (age_q < TO_LIM) age_d = age_q + 16'd1;
    else                    age_d = age_q;
    timeout_d = timeout_q | (age_d == TO_LIM);
`else
    timeout_d = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      queue_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      ack_q     <= 1'b0;
      ack_we_q  <= 1'b0;
      data_q    <= '0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      queue_q   <= queue_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      ack_q     <= ack_d;
      ack_we_q  <= ack_we_d;
      data_q    <= data_d;
      err_q     <= err_d;
      timeout_q <= timeout_d;
    end
  end

`ifdef MCT_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) age_q <= '0;
    else     age_q <= age_d;
  end
`endif

  assign ack            = ack_q;
  assign ack_we         = ack_we_q;
  assign data_out       = data_q;
  assign outstanding    = cnt_q;
  assign err_unexpected = err_q;
  assign timeout_o      = timeout_q;
endmodule
